// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared types, opcodes, mux encodings and small decode helpers
//            for the multicycle RV32I control unit.
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

  // Controller states; one instruction walks 3 to 5 of these (plus waits).
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALRADR  = 4'd10,
    S_JAL      = 4'd11,
    S_UPPER    = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  // What the ALU is asked to do in a given state.
  typedef enum logic [1:0] {
    ALU_CLS_ADD  = 2'd0,
    ALU_CLS_SUB  = 2'd1,
    ALU_CLS_FUNC = 2'd2
  } alu_class_t;

  // RV32I major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // Datapath mux encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // State that follows DECODE; unknown opcodes and reserved branch funct3 trap.
  function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] funct3);
    state_t nxt;
    case (op)
      OP_LOAD, OP_STORE: nxt = S_MEMADR;
      OP_R:              nxt = S_EXECR;
      OP_IMM:            nxt = S_EXECI;
      OP_BRANCH:         nxt = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
      OP_JAL:            nxt = S_JAL;
      OP_JALR:           nxt = S_JALRADR;
      OP_LUI, OP_AUIPC:  nxt = S_UPPER;
      default:           nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

  // Branch resolution from the ALU flags of the rs1-rs2 compare.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic lt, input logic ltu);
    logic cond;
    case (funct3[2:1])
      2'b00:   cond = zero;
      2'b10:   cond = lt;
      2'b11:   cond = ltu;
      default: cond = 1'b0;
    endcase
    // Odd funct3 values are the negated forms (bne/bge/bgeu).
    return funct3[0] ? ~cond : cond;
  endfunction

  // Immediate format selected purely from the opcode.
  function automatic logic [2:0] imm_select(input logic [6:0] op);
    logic [2:0] sel;
    case (op)
      OP_LOAD, OP_JALR, OP_IMM: sel = IMM_I;
      OP_STORE:                 sel = IMM_S;
      OP_BRANCH:                sel = IMM_B;
      OP_LUI, OP_AUIPC:         sel = IMM_U;
      OP_JAL:                   sel = IMM_J;
      default:                  sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Purpose  : Combinational ALU function select from state class, funct3,
//            funct7 bit 5 and opcode bit 5 (R-type vs I-type).
// Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 4
) (
  input  alu_class_t           alu_class,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 opb5,
  output logic [ALUCTRL_W-1:0] alu_control
);

  logic [3:0] alu_code;

  // Pick the ALU operation; only the FUNC class looks at the instruction fields.
  always_comb begin
    alu_code = ALU_ADD;
    case (alu_class)
      ALU_CLS_ADD: alu_code = ALU_ADD;
      ALU_CLS_SUB: alu_code = ALU_SUB;
      ALU_CLS_FUNC: begin
        case (funct3)
          // addi has no sub form, so funct7b5 only matters for R-type.
          3'b000:  alu_code = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_code = ALU_SLL;
          3'b010:  alu_code = ALU_SLT;
          3'b011:  alu_code = ALU_SLTU;
          3'b100:  alu_code = ALU_XOR;
          3'b101:  alu_code = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_code = ALU_OR;
          default: alu_code = ALU_AND;
        endcase
      end
      default: alu_code = ALU_ADD;
    endcase
  end

  assign alu_control = ALUCTRL_W'(alu_code);

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Moore-style multicycle RV32I control FSM driving a shared ALU
//            and a single unified memory port, with ready handshake and trap.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W     = 4,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 Lt,
  input  logic                 LtU,
  input  logic                 MemReady,
  output logic                 MemReq,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [2:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 InstrDone,
  output logic                 Trap
);

  state_t     state;
  state_t     out_state;
  alu_class_t alu_class;
  logic       mem_ready;

  // Without the handshake every memory access completes in one cycle.
  assign mem_ready = MEM_HANDSHAKE ? MemReady : 1'b1;

  // State sequencing; reset wins in every state, including TRAP and waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE:   state <= decode_next(op, funct3);
        S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JALRADR:  state <= S_JAL;
        S_JAL:      state <= S_ALUWB;
        S_UPPER:    state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // While reset is high the outputs look like an idle FETCH with no strobes.
  assign out_state = reset ? S_FETCH : state;

  // Per-state datapath controls; strobes depending on MemReady or flags are
  // resolved in the same cycle so a stalled access never writes IR or PC.
  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    alu_class = ALU_CLS_ADD;
    InstrDone = 1'b0;
    Trap      = 1'b0;
    case (out_state)
      S_FETCH: begin
        MemReq    = ~reset;
        IRWrite   = ~reset & mem_ready;
        PCWrite   = ~reset & mem_ready;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_READDATA;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMWRITE: begin
        MemReq    = 1'b1;
        MemWrite  = 1'b1;
        AdrSrc    = 1'b1;
        InstrDone = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        alu_class = ALU_CLS_FUNC;
      end
      S_EXECI: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        alu_class = ALU_CLS_FUNC;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        alu_class = ALU_CLS_SUB;
        PCWrite   = branch_taken(funct3, Zero, Lt, LtU);
        InstrDone = 1'b1;
      end
      S_JALRADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut while the ALU forms OldPC+4.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_UPPER: begin
        ALUSrcA = op[5] ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_TRAP: begin
        Trap = 1'b1;
      end
      default: begin
        Trap = 1'b0;
      end
    endcase
  end

  assign ImmSrc = imm_select(op);

  alu_decoder #(
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_decoder (
    .alu_class   (alu_class),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .opb5        (op[5]),
    .alu_control (ALUControl)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Scoreboard bench for the multicycle controller: each issued
//            cycle pushes the expected control word, a monitor pops/compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  // Phase names for the bench's own instruction-timeline model.
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                 P_MEMWR = 5, P_EXR = 6, P_EXI = 7, P_ALUWB = 8, P_BR = 9,
                 P_JALRADR = 10, P_JAL = 11, P_UPPER = 12, P_TRAP = 13, P_RST = 14;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                         JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111;

  typedef struct packed {
    logic       mreq, mwr, irw, pcw, rw, adr;
    logic [1:0] sa, sb, rs;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       done, trap;
  } ctl_t;

  typedef struct {
    int ph;
    bit mem;
    bit rdy;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0, Lt = 1'b0, LtU = 1'b0, MemReady = 1'b0;
  logic       sel = 1'b0;
  bit         nh_mode = 1'b0;

  logic       h_mreq, h_mwr, h_irw, h_pcw, h_rw, h_adr, h_done, h_trap;
  logic [1:0] h_sa, h_sb, h_rs;
  logic [2:0] h_imm;
  logic [3:0] h_alu;
  logic       n_mreq, n_mwr, n_irw, n_pcw, n_rw, n_adr, n_done, n_trap;
  logic [1:0] n_sa, n_sb, n_rs;
  logic [2:0] n_imm;
  logic [3:0] n_alu;

  ctl_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.ALUCTRL_W(4), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .LtU(LtU), .MemReady(MemReady),
    .MemReq(h_mreq), .MemWrite(h_mwr), .IRWrite(h_irw), .PCWrite(h_pcw),
    .RegWrite(h_rw), .AdrSrc(h_adr), .ALUSrcA(h_sa), .ALUSrcB(h_sb),
    .ResultSrc(h_rs), .ImmSrc(h_imm), .ALUControl(h_alu),
    .InstrDone(h_done), .Trap(h_trap)
  );

  // Second instance: handshake disabled, MemReady tied low.
  multicycle_controller #(.ALUCTRL_W(4), .MEM_HANDSHAKE(1'b0)) dut_nh (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .LtU(LtU), .MemReady(1'b0),
    .MemReq(n_mreq), .MemWrite(n_mwr), .IRWrite(n_irw), .PCWrite(n_pcw),
    .RegWrite(n_rw), .AdrSrc(n_adr), .ALUSrcA(n_sa), .ALUSrcB(n_sb),
    .ResultSrc(n_rs), .ImmSrc(n_imm), .ALUControl(n_alu),
    .InstrDone(n_done), .Trap(n_trap)
  );

  function automatic bit legal(input logic [6:0] o, input logic [2:0] f3);
    if (o == BR) return (f3 != 3'b010) && (f3 != 3'b011);
    return (o == LD) || (o == ST) || (o == RT) || (o == IT) || (o == JL) ||
           (o == JR) || (o == LU) || (o == AU);
  endfunction

  // Reference: the control word the specification demands for one cycle.
  function automatic ctl_t model(input int ph, input bit rdy, input logic [6:0] o,
                                 input logic [2:0] f3, input logic f7,
                                 input logic z, input logic lt, input logic ltu);
    ctl_t c;
    bit   tk;
    c = '0;
    if (o == LD || o == JR || o == IT) c.imm = 3'd0;
    else if (o == ST) c.imm = 3'd1;
    else if (o == BR) c.imm = 3'd2;
    else if (o == LU || o == AU) c.imm = 3'd3;
    else if (o == JL) c.imm = 3'd4;
    case (ph)
      P_RST:   begin c.sb = 2'b10; c.rs = 2'b10; end
      P_FETCH: begin c.mreq = 1; c.sb = 2'b10; c.rs = 2'b10; c.irw = rdy; c.pcw = rdy; end
      P_DECODE, P_UPPER: begin
        c.sa = (ph == P_UPPER && o == LU) ? 2'b11 : 2'b01; c.sb = 2'b01;
      end
      P_MEMADR, P_JALRADR: begin c.sa = 2'b10; c.sb = 2'b01; end
      P_MEMRD: begin c.mreq = 1; c.adr = 1; end
      P_MEMWB: begin c.rs = 2'b01; c.rw = 1; c.done = 1; end
      P_MEMWR: begin c.mreq = 1; c.mwr = 1; c.adr = 1; c.done = rdy; end
      P_EXR, P_EXI: begin
        c.sa = 2'b10; c.sb = (ph == P_EXI) ? 2'b01 : 2'b00;
        case (f3)
          3'd0: c.alu = (ph == P_EXR && f7) ? 4'd1 : 4'd0;
          3'd1: c.alu = 4'd7;
          3'd2: c.alu = 4'd5;
          3'd3: c.alu = 4'd6;
          3'd4: c.alu = 4'd4;
          3'd5: c.alu = f7 ? 4'd9 : 4'd8;
          3'd6: c.alu = 4'd3;
          default: c.alu = 4'd2;
        endcase
      end
      P_ALUWB: begin c.rw = 1; c.done = 1; end
      P_BR: begin
        case (f3)
          3'd0: tk = z;      3'd1: tk = !z;
          3'd4: tk = lt;     3'd5: tk = !lt;
          3'd6: tk = ltu;    default: tk = !ltu;
        endcase
        c.sa = 2'b10; c.alu = 4'd1; c.pcw = tk; c.done = 1;
      end
      P_JAL:  begin c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1; end
      P_TRAP: c.trap = 1;
      default: c = c;
    endcase
    return c;
  endfunction

  // One cycle of stimulus: drive the inputs, push what the DUT must show.
  task automatic drive(input int ph, input bit mem, input bit rdy, input bit rf,
                       input logic [2:0] fv);
    logic [2:0] f;
    f = rf ? 3'($urandom) : fv;
    reset = (ph == P_RST);
    {Zero, Lt, LtU} = f;
    MemReady = mem ? rdy : 1'($urandom);
    sb_q.push_back(model(ph, nh_mode ? 1'b1 : rdy, op, funct3, funct7b5, f[2], f[1], f[0]));
    @(posedge clk);
    #1;
  endtask

  // Build the cycle timeline of one instruction, optionally aborted by reset.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int wf_in, input int wm_in, input int cut_in,
                           input int nrst_in, input bit rf, input logic [2:0] fv);
    ent_t s[$];
    int   wf, wm, cut, nrst;
    wf = nh_mode ? 0 : wf_in;
    wm = nh_mode ? 0 : wm_in;
    cut = cut_in;
    nrst = nrst_in;
    op = o; funct3 = f3; funct7b5 = f7;
    for (int i = 0; i < wf; i++) s.push_back('{P_FETCH, 1'b1, 1'b0});
    s.push_back('{P_FETCH, 1'b1, 1'b1});
    s.push_back('{P_DECODE, 1'b0, 1'b0});
    if (!legal(o, f3)) begin
      for (int i = 0; i < 2 + int'($urandom_range(0, 2)); i++) s.push_back('{P_TRAP, 1'b0, 1'b0});
      cut = -1;
      if (nrst < 1) nrst = 1;
    end else if (o == LD || o == ST) begin
      s.push_back('{P_MEMADR, 1'b0, 1'b0});
      for (int i = 0; i < wm; i++) s.push_back('{(o == LD) ? P_MEMRD : P_MEMWR, 1'b1, 1'b0});
      s.push_back('{(o == LD) ? P_MEMRD : P_MEMWR, 1'b1, 1'b1});
      if (o == LD) s.push_back('{P_MEMWB, 1'b0, 1'b0});
    end else if (o == BR) begin
      s.push_back('{P_BR, 1'b0, 1'b0});
    end else begin
      if (o == RT) s.push_back('{P_EXR, 1'b0, 1'b0});
      if (o == IT) s.push_back('{P_EXI, 1'b0, 1'b0});
      if (o == LU || o == AU) s.push_back('{P_UPPER, 1'b0, 1'b0});
      if (o == JR) s.push_back('{P_JALRADR, 1'b0, 1'b0});
      if (o == JR || o == JL) s.push_back('{P_JAL, 1'b0, 1'b0});
      s.push_back('{P_ALUWB, 1'b0, 1'b0});
    end
    if (cut >= 0) while (s.size() > cut) void'(s.pop_back());
    foreach (s[i]) drive(s[i].ph, s[i].mem, s[i].rdy, rf, fv);
    for (int i = 0; i < nrst; i++) drive(P_RST, 1'b0, 1'b0, 1'b1, 3'b000);
  endtask

  task automatic run_random(input int n);
    logic [6:0] o;
    int         cut;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 10))
        0, 10: o = LD;  1: o = ST;  2: o = RT;  3: o = IT;  4: o = BR;
        5: o = JL;  6: o = JR;  7: o = LU;  8: o = AU;
        default: begin
          case ($urandom_range(0, 3))
            0: o = 7'b0000000;  1: o = 7'b0001111;
            2: o = 7'b1110011;  default: o = 7'b1111111;
          endcase
        end
      endcase
      cut = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_instr(o, 3'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), cut,
                (cut >= 0) ? int'($urandom_range(1, 3)) : 0, 1'b1, 3'b000);
    end
  endtask

  // Monitor: every cycle that has an expectation, compare the selected DUT.
  always @(negedge clk) begin
    ctl_t exp_c, act_c;
    if (sb_q.size() > 0) begin
      exp_c = sb_q.pop_front();
      if (sel)
        act_c = {n_mreq, n_mwr, n_irw, n_pcw, n_rw, n_adr, n_sa, n_sb, n_rs, n_imm, n_alu, n_done, n_trap};
      else
        act_c = {h_mreq, h_mwr, h_irw, h_pcw, h_rw, h_adr, h_sa, h_sb, h_rs, h_imm, h_alu, h_done, h_trap};
      checks++;
      if (act_c === exp_c) passes++;
      else $display("FAIL ctl_word t=%0t nh=%0d op=%b f3=%b actual=%h required=%h",
                    $time, sel, op, funct3, act_c, exp_c);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) drive(P_RST, 1'b0, 1'b0, 1'b1, 3'b000);
    // Directed cases from the test plan.
    run_instr(RT, 3'b000, 1'b1, 0, 0, -1, 0, 1'b1, 3'b000);   // add/sub, 4 cycles
    run_instr(LD, 3'b010, 1'b0, 0, 2, -1, 0, 1'b1, 3'b000);   // lw, 2 waits -> 7 cycles
    run_instr(BR, 3'b001, 1'b0, 0, 0, -1, 0, 1'b0, 3'b000);   // bne Zero=0 taken
    run_instr(BR, 3'b001, 1'b0, 0, 0, -1, 0, 1'b0, 3'b100);   // bne Zero=1 not taken
    run_instr(BR, 3'b110, 1'b0, 0, 0, -1, 0, 1'b0, 3'b001);   // bltu LtU=1 taken
    run_instr(BR, 3'b111, 1'b0, 0, 0, -1, 0, 1'b0, 3'b001);   // bgeu LtU=1 not taken
    run_instr(BR, 3'b100, 1'b0, 0, 0, -1, 0, 1'b0, 3'b010);   // blt Lt=1 taken
    run_instr(JR, 3'b000, 1'b0, 1, 0, -1, 0, 1'b1, 3'b000);   // jalr with fetch wait
    run_instr(IT, 3'b101, 1'b1, 0, 0, -1, 0, 1'b1, 3'b000);   // srai -> SRA
    run_instr(LU, 3'b000, 1'b0, 0, 0, -1, 0, 1'b1, 3'b000);   // lui
    run_instr(AU, 3'b000, 1'b0, 0, 0, -1, 0, 1'b1, 3'b000);   // auipc
    run_instr(BR, 3'b010, 1'b0, 0, 0, -1, 2, 1'b1, 3'b000);   // reserved branch -> trap
    run_instr(ST, 3'b010, 1'b0, 0, 3, 4, 2, 1'b1, 3'b000);    // reset mid store wait
    run_instr(ST, 3'b010, 1'b0, 0, 1, -1, 0, 1'b1, 3'b000);   // sw with one wait
    run_random(150);
    // Handshake-disabled instance: MemReady is tied low yet accesses complete.
    drive(P_RST, 1'b0, 1'b0, 1'b1, 3'b000);
    sel = 1'b1;
    nh_mode = 1'b1;
    drive(P_RST, 1'b0, 1'b0, 1'b1, 3'b000);
    drive(P_RST, 1'b0, 1'b0, 1'b1, 3'b000);
    run_instr(ST, 3'b010, 1'b0, 0, 0, -1, 0, 1'b1, 3'b000);   // sw in 4 cycles
    run_instr(LD, 3'b010, 1'b0, 0, 0, -1, 0, 1'b1, 3'b000);   // lw in 5 cycles
    run_random(60);
    repeat (2) @(posedge clk);
    checks++;
    if (sb_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle RV32I control unit. A Moore-style FSM sequences each instruction over 3–5 cycles and reuses one ALU and one unified memory port. It adds full branch-condition decode, jalr/lui/auipc, shifts and xor, a memory-ready handshake, and an illegal-instruction trap. It drives the multicycle datapath muxes and enables; ALU function decode sits in a child module.

## Interface
Parameters:
- ALUCTRL_W, 4 — ALUControl width; must be ≥4.
- MEM_HANDSHAKE, 1 — 1: memory states wait for MemReady; 0: MemReady is ignored and treated as 1.

Ports:
- clk  in  1  — single clock, rising edge.
- reset  in  1  — synchronous, active-high.
- op  in  7  — instruction opcode.
- funct3  in  3  — instruction funct3.
- funct7b5  in  1  — instruction bit 30.
- Zero, Lt, LtU  in  1 each  — ALU flags for the current-cycle result: equal, signed less-than, unsigned less-than.
- MemReady  in  1  — memory completes the current access this cycle.
- MemReq  out  1  — memory access request.
- MemWrite  out  1  — store strobe.
- IRWrite, PCWrite, RegWrite  out  1 each  — register write enables.
- AdrSrc  out  1  — memory address select: 0=PC, 1=ALUOut.
- ALUSrcA  out  2  — 00=PC, 01=OldPC, 10=rs1, 11=zero.
- ALUSrcB  out  2  — 00=rs2, 01=Imm, 10=const 4.
- ResultSrc  out  2  — 00=ALUOut, 01=ReadData, 10=ALUResult.
- ImmSrc  out  3  — 000 I, 001 S, 010 B, 011 U, 100 J.
- ALUControl  out  ALUCTRL_W  — ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9.
- InstrDone  out  1  — one-cycle pulse in the final cycle of every retired instruction.
- Trap  out  1  — high while in TRAP.

## Operation
States and the signals each drives. Any signal not listed is 0 or 00.
- FETCH: MemReq, AdrSrc=0, SrcA=00, SrcB=10, ADD, ResultSrc=10. IRWrite and PCWrite are asserted only in the MemReady cycle, which is also the exit condition → DECODE.
- DECODE: SrcA=01, SrcB=01, ADD, so ALUOut receives the branch/jal target.
  - Next state by op: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALRADR; 0110111/0010111 → UPPER.
  - Any other op, or a branch with funct3 010/011, → TRAP.
- MEMADR: SrcA=10, SrcB=01, ADD → MEMREAD (op[5]=0) or MEMWRITE.
- MEMREAD: MemReq, AdrSrc=1; waits for MemReady → MEMWB.
- MEMWB: ResultSrc=01, RegWrite, InstrDone → FETCH.
- MEMWRITE: MemReq, MemWrite, AdrSrc=1; waits for MemReady, with InstrDone in that cycle → FETCH.
- EXECR: SrcA=10, SrcB=00, ALU decoded from funct3/funct7b5 → ALUWB.
- EXECI: SrcA=10, SrcB=01, ALU decoded from funct3 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite, InstrDone → FETCH.
- BRANCH: SrcA=10, SrcB=00, SUB, ResultSrc=00. PCWrite = taken, where taken per funct3: 000 Zero, 001 !Zero, 100 Lt, 101 !Lt, 110 LtU, 111 !LtU. InstrDone → FETCH.
- JALRADR: SrcA=10, SrcB=01, ADD → JAL.
- JAL: SrcA=01, SrcB=10, ADD, ResultSrc=00, PCWrite → ALUWB. This writes the link OldPC+4.
- UPPER: SrcA=11 (lui) or 01 (auipc), SrcB=01, ADD → ALUWB.
- TRAP: all enables 0, Trap=1. Sticky until reset.

ImmSrc is decoded combinationally from op in every state: load/jalr/OP-IMM → I, store → S, branch → B, lui/auipc → U, jal → J, otherwise 000.

ALU decode for EXECR/EXECI, by funct3:
- 000: SUB only when R-type and funct7b5; otherwise ADD.
- 001: SLL.
- 010: SLT.
- 011: SLTU.
- 100: XOR.
- 101: SRA if funct7b5, else SRL.
- 110: OR.
- 111: AND.

## Timing
- Zero-wait cycle counts: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui/auipc 4.
- Each FETCH/MEMREAD/MEMWRITE cycle with MemReady=0 adds one cycle.
- Memory handshake:
  - MemReq and MemWrite stay high through wait cycles.
  - IRWrite and PCWrite are never asserted while waiting.
  - MemReady is ignored whenever MemReq=0.
- Reset:
  - State becomes FETCH at the edge where reset is sampled high.
  - While reset=1, MemReq, MemWrite, IRWrite, PCWrite, RegWrite, InstrDone and Trap are forced to 0; muxes show their FETCH values.
  - Reset asserted in any state, including a pending memory wait or TRAP, aborts the instruction with no write strobe in that cycle.
- InstrDone and RegWrite/PCWrite coincide in the final cycle; there are never two InstrDone pulses without an intervening FETCH.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum;
  - opcode localparams;
  - ALU op codes;
  - ALUSrcA/ALUSrcB/ResultSrc/ImmSrc encodings.
- Sub-module alu_decoder is combinational: inputs state class (add/sub/func), funct3, funct7b5, opb5; output ALUControl.

## Test plan
- Reset held 3 cycles then released, MemReady=1 → MemReq=1 and state FETCH in the first cycle; the add x1,x2,x3 sequence yields RegWrite on cycle 4 with ALUControl=SUB for funct7b5=1 in EXECR.
- lw with MemReady low 2 cycles in MEMREAD → RegWrite/InstrDone on cycle 7; no IRWrite or PCWrite during the waits.
- bne (funct3 001) with Zero=0 → PCWrite=1 in cycle 3; with Zero=1 → PCWrite=0; InstrDone=1 in both cases.
- bltu with LtU=1 → taken; bgeu with LtU=1 → not taken; funct3=010 → Trap=1 from cycle 3 and held until reset.
- jalr → JALRADR, then JAL with PCWrite, then ALUWB with RegWrite; 5 cycles total; srai (funct3 101, funct7b5=1) → ALUControl=9.
- Reset asserted during a MEMWRITE wait → MemWrite low in that cycle, then FETCH; with MEM_HANDSHAKE=0 and MemReady tied 0, sw completes in 4 cycles.
